map_table_mp: RTL and testbench
===============================

# map_table_mp

Parametrised multi-port register map table (register alias table) in the rename/dispatch stage of the Tomasulo core. It tracks, per architectural register, the ROB tag of its youngest in-flight producer and whether that producer's value already sits in the ROB. It renames up to DISPATCH_W instructions per cycle with intra-group dependency forwarding. It absorbs CDB_W completion broadcasts and one retirement per cycle, and clears wholesale on a mispredict flush.

## Interface
- ARCH_REGS, 32: architectural register count; register 0 is hard-wired zero.
- TAG_W, 4: ROB tag width; the all-ones tag (NULL_TAG) means "no producer".
- DISPATCH_W, 2: rename slots per cycle; slot 0 is oldest.
- CDB_W, 2: CDB broadcast ports.
- REG_W, $clog2(ARCH_REGS): derived; not overridable.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  mispredict recovery; clears all mappings.
- disp_valid  in  DISPATCH_W  per-slot rename request.
- disp_src1, disp_src2, disp_dest  in  DISPATCH_W*REG_W  per-slot architectural registers.
- disp_tag  in  DISPATCH_W*TAG_W  per-slot ROB tag allocated to the destination.
- cdb_valid  in  CDB_W  broadcast valid.
- cdb_tag  in  CDB_W*TAG_W  completing ROB tag.
- commit_valid  in  1  ROB retirement.
- commit_dest  in  REG_W  retiring architectural register.
- commit_tag  in  TAG_W  retiring ROB tag.
- src1_stat, src2_stat  out  DISPATCH_W*2  encoding: 00 = read regfile, 10 = wait on tag, 11 = read ROB.
- src1_tag, src2_tag  out  DISPATCH_W*TAG_W  producer tag; NULL_TAG when stat is 00.

## Operation
- State: per register {tag, ready}. Reset value is tag = NULL_TAG, ready = 0.
- Lookup is combinational from current state, per slot and source:
  - A source of 0, or a register whose tag is NULL_TAG, returns 00/NULL_TAG.
  - Otherwise it returns 11 if ready, else 10, with the stored tag.
- Intra-group forwarding: if an older valid slot i < j in the same cycle has disp_dest equal to slot j's source (non-zero), slot j returns 10 with disp_tag[i]. The youngest such i wins. This overrides table contents.
- Next-state update order, where a later step overrides an earlier one:
  1. CDB: every entry whose current tag equals any valid cdb_tag (not NULL_TAG) sets ready = 1.
  2. Commit: if commit_valid and the entry tag of commit_dest equals commit_tag, the entry becomes NULL_TAG/0. A stale commit (tag mismatch) is a no-op.
  3. Dispatch, applied in slot order 0..DISPATCH_W-1: a valid slot with disp_dest ≠ 0 writes {disp_tag, 0}. With duplicate destinations, the youngest slot wins. A dest of 0 is never mapped.
  4. Flush: all entries become NULL_TAG/0, and same-cycle dispatch/CDB/commit are discarded.
- A register both committed and renamed in the same cycle ends holding the new tag, not ready.
- Outputs carry no stat/tag dependency on flush in the same cycle; upstream squashes dispatch on flush.

## Timing
- Lookup latency is 0 cycles (combinational on current state plus same-cycle disp_* inputs).
- State updates become visible to lookups on the next rising edge.
- Reset is asynchronous assert and synchronous-release by the system. While reset is low, all outputs read as 00/NULL_TAG for any source.
- Reset mid-operation discards all mappings immediately.
- A ready bit set by CDB in cycle n is seen by lookups in cycle n+1 (see Configuration for same-cycle).
- There is no backpressure: every valid slot is accepted every cycle. Upstream guarantees ROB tag uniqueness.

## Configuration
- MAP_TABLE_CDB_BYPASS_EN:
  - Defined: a lookup returning 10 whose tag equals a valid same-cycle cdb_tag is promoted to 11. This includes intra-group-forwarded tags.
  - Undefined: no promotion; the source reports 10 for that cycle and 11 from the next cycle.
  - State update is identical in both builds.

## Test plan
- Reset, then slot0 renames dest 5 to tag 3. Next cycle, src1 = 5 gives 10/3. CDB tag 3, then next cycle src1 = 5 gives 11/3. Commit (5, 3), then next cycle gives 00/NULL_TAG.
- Same cycle: slot0 dest 7 tag 2, slot1 src1 = 7 and src2 = 0 → slot1 src1 gives 10/2, src2 gives 00/NULL_TAG. Both slots with dest 9 (tags 4, 6) → reg 9 holds 6.
- Reg 8 mapped to tag 1; commit (8, 5) → no change. Commit (8, 1) plus slot0 renaming 8 to tag 7 in the same cycle → reg 8 gives 10/7.
- Regs 3 and 4 mapped, CDB tag matching reg 3 asserted with flush → next cycle every source gives 00/NULL_TAG. Drop reset low mid-run → outputs 00/NULL_TAG immediately.
- Reg 6 mapped to tag 2; CDB tag 2 while slot0 reads src1 = 6 → 11/2 with MAP_TABLE_CDB_BYPASS_EN, 10/2 without. Both builds give 11/2 the next cycle.

Source files
------------

// File: rtl/map_table_mp.sv
// Register alias table: per arch reg, youngest producer ROB tag plus ready bit; renames DISPATCH_W slots per cycle.
// Lookup latency 0 cycles, state visible next edge; no backpressure, every valid slot is accepted.
// Optional MAP_TABLE_CDB_BYPASS_EN promotes wait-on-tag lookups that match a same-cycle CDB tag to read-ROB.
module map_table_mp #(
    parameter int ARCH_REGS  = 32,
    parameter int TAG_W      = 4,
    parameter int DISPATCH_W = 2,
    parameter int CDB_W      = 2,
    localparam int REG_W     = $clog2(ARCH_REGS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush,
    input  logic [DISPATCH_W-1:0]       disp_valid,
    input  logic [DISPATCH_W*REG_W-1:0] disp_src1,
    input  logic [DISPATCH_W*REG_W-1:0] disp_src2,
    input  logic [DISPATCH_W*REG_W-1:0] disp_dest,
    input  logic [DISPATCH_W*TAG_W-1:0] disp_tag,
    input  logic [CDB_W-1:0]            cdb_valid,
    input  logic [CDB_W*TAG_W-1:0]      cdb_tag,
    input  logic                        commit_valid,
    input  logic [REG_W-1:0]            commit_dest,
    input  logic [TAG_W-1:0]            commit_tag,
    output logic [DISPATCH_W*2-1:0]     src1_stat,
    output logic [DISPATCH_W*2-1:0]     src2_stat,
    output logic [DISPATCH_W*TAG_W-1:0] src1_tag,
    output logic [DISPATCH_W*TAG_W-1:0] src2_tag
);
    localparam logic [TAG_W-1:0] NULL_TAG = '1;

    logic [ARCH_REGS-1:0][TAG_W-1:0] tag_q, tag_d;
    logic [ARCH_REGS-1:0]            rdy_q, rdy_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_q <= {ARCH_REGS{NULL_TAG}};
            rdy_q <= '0;
        end else begin
            tag_q <= tag_d;
            rdy_q <= rdy_d;
        end
    end

    function automatic logic cdb_hit(input logic [TAG_W-1:0] t);
        logic hit;
        hit = 1'b0;
        for (int c = 0; c < CDB_W; c++) begin
            if (cdb_valid[c] && cdb_tag[c*TAG_W +: TAG_W] == t && t != NULL_TAG) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    // CDB, then commit, then dispatch in slot order; flush overrides all.
    always_comb begin
        tag_d = tag_q;
        rdy_d = rdy_q;
        for (int r = 0; r < ARCH_REGS; r++) begin
            if (cdb_hit(tag_q[r])) begin
                rdy_d[r] = 1'b1;
            end
            if (commit_valid && commit_dest == REG_W'(r) && tag_q[r] == commit_tag) begin
                tag_d[r] = NULL_TAG;
                rdy_d[r] = 1'b0;
            end
            for (int s = 0; s < DISPATCH_W; s++) begin
                if (r != 0 && disp_valid[s] && disp_dest[s*REG_W +: REG_W] == REG_W'(r)) begin
                    tag_d[r] = disp_tag[s*TAG_W +: TAG_W];
                    rdy_d[r] = 1'b0;
                end
            end
        end
        if (flush) begin
            tag_d = {ARCH_REGS{NULL_TAG}};
            rdy_d = '0;
        end
    end

    function automatic logic [TAG_W+1:0] lookup(input int slot, input logic [REG_W-1:0] src);
        logic [1:0]       st;
        logic [TAG_W-1:0] tg;
        st = 2'b00;
        tg = NULL_TAG;
        for (int r = 0; r < ARCH_REGS; r++) begin
            if (src != '0 && src == REG_W'(r) && tag_q[r] != NULL_TAG) begin
                st = rdy_q[r] ? 2'b11 : 2'b10;
                tg = tag_q[r];
            end
        end
        // Later (younger) older-slot matches override earlier ones.
        for (int i = 0; i < DISPATCH_W; i++) begin
            if (i < slot && disp_valid[i] && src != '0 && disp_dest[i*REG_W +: REG_W] == src) begin
                st = 2'b10;
                tg = disp_tag[i*TAG_W +: TAG_W];
            end
        end
`ifdef MAP_TABLE_CDB_BYPASS_EN
        if (st == 2'b10 && cdb_hit(tg)) begin
            st = 2'b11;
        end
`endif
        if (!reset) begin
            st = 2'b00;
            tg = NULL_TAG;
        end
        return {st, tg};
    endfunction

    always_comb begin
        src1_stat = '0;
        src2_stat = '0;
        src1_tag  = '0;
        src2_tag  = '0;
        for (int s = 0; s < DISPATCH_W; s++) begin
            {src1_stat[s*2 +: 2], src1_tag[s*TAG_W +: TAG_W]} = lookup(s, disp_src1[s*REG_W +: REG_W]);
            {src2_stat[s*2 +: 2], src2_tag[s*TAG_W +: TAG_W]} = lookup(s, disp_src2[s*REG_W +: REG_W]);
        end
    end
endmodule

// File: tb/tb_map_table_mp.sv
// Randomised and directed bench for map_table_mp against an array-based reference model.
module tb_map_table_mp;
    localparam int AR = 32;
    localparam int TW = 4;
    localparam int DW = 2;
    localparam int CW = 2;
    localparam int RW = 5;
    localparam logic [TW-1:0] NT = 4'hF;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush;
    logic [DW-1:0]    disp_valid;
    logic [DW*RW-1:0] disp_src1, disp_src2, disp_dest;
    logic [DW*TW-1:0] disp_tag;
    logic [CW-1:0]    cdb_valid;
    logic [CW*TW-1:0] cdb_tag;
    logic             commit_valid;
    logic [RW-1:0]    commit_dest;
    logic [TW-1:0]    commit_tag;
    logic [DW*2-1:0]  src1_stat, src2_stat;
    logic [DW*TW-1:0] src1_tag, src2_tag;

    map_table_mp dut (
        .clk(clk), .reset(rst_n), .flush(flush),
        .disp_valid(disp_valid), .disp_src1(disp_src1), .disp_src2(disp_src2),
        .disp_dest(disp_dest), .disp_tag(disp_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .commit_valid(commit_valid), .commit_dest(commit_dest), .commit_tag(commit_tag),
        .src1_stat(src1_stat), .src2_stat(src2_stat), .src1_tag(src1_tag), .src2_tag(src2_tag)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [TW-1:0] m_tag [AR];
    logic          m_rdy [AR];

    task automatic check(string name, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, obs, exp);
        end
    endtask

    function automatic logic [5:0] get_out(int s, int which);
        if (which == 1) return {src1_stat[s*2 +: 2], src1_tag[s*TW +: TW]};
        return {src2_stat[s*2 +: 2], src2_tag[s*TW +: TW]};
    endfunction

    function automatic logic [5:0] ref_lookup(int slot, logic [RW-1:0] src);
        logic [1:0]    st;
        logic [TW-1:0] tg;
        st = 2'b00;
        tg = NT;
        if (!rst_n) return {2'b00, NT};
        if (src != 0 && m_tag[src] != NT) begin
            tg = m_tag[src];
            st = m_rdy[src] ? 2'b11 : 2'b10;
        end
        for (int i = slot - 1; i >= 0; i--) begin
            if (disp_valid[i] && src != 0 && disp_dest[i*RW +: RW] == src) begin
                st = 2'b10;
                tg = disp_tag[i*TW +: TW];
                break;
            end
        end
`ifdef MAP_TABLE_CDB_BYPASS_EN
        if (st == 2'b10)
            for (int c = 0; c < CW; c++)
                if (cdb_valid[c] && tg != NT && cdb_tag[c*TW +: TW] == tg) st = 2'b11;
`endif
        return {st, tg};
    endfunction

    task automatic model_clear();
        for (int r = 0; r < AR; r++) begin
            m_tag[r] = NT;
            m_rdy[r] = 1'b0;
        end
    endtask

    task automatic model_update();
        logic [TW-1:0] nt [AR];
        logic          nr [AR];
        if (flush) begin
            model_clear();
            return;
        end
        nt = m_tag;
        nr = m_rdy;
        for (int r = 0; r < AR; r++)
            for (int c = 0; c < CW; c++)
                if (cdb_valid[c] && m_tag[r] != NT && cdb_tag[c*TW +: TW] == m_tag[r]) nr[r] = 1'b1;
        if (commit_valid && m_tag[commit_dest] == commit_tag) begin
            nt[commit_dest] = NT;
            nr[commit_dest] = 1'b0;
        end
        for (int s = 0; s < DW; s++)
            if (disp_valid[s] && disp_dest[s*RW +: RW] != 0) begin
                nt[disp_dest[s*RW +: RW]] = disp_tag[s*TW +: TW];
                nr[disp_dest[s*RW +: RW]] = 1'b0;
            end
        m_tag = nt;
        m_rdy = nr;
    endtask

    task automatic check_outputs(string pfx);
        for (int s = 0; s < DW; s++) begin
            check($sformatf("%s_s%0d_src1", pfx, s), get_out(s, 1), ref_lookup(s, disp_src1[s*RW +: RW]));
            check($sformatf("%s_s%0d_src2", pfx, s), get_out(s, 2), ref_lookup(s, disp_src2[s*RW +: RW]));
        end
    endtask

    // Called at a falling edge with inputs already applied.
    task automatic step(string pfx);
        #1;
        if (!rst_n) model_clear();
        check_outputs(pfx);
        @(posedge clk);
        if (rst_n) model_update();
        @(negedge clk);
    endtask

    task automatic idle();
        flush = 1'b0;
        disp_valid = '0; disp_src1 = '0; disp_src2 = '0; disp_dest = '0; disp_tag = '0;
        cdb_valid = '0; cdb_tag = '0;
        commit_valid = 1'b0; commit_dest = '0; commit_tag = '0;
    endtask

    task automatic set_slot(int s, bit v, int s1, int s2, int d, int t);
        disp_valid[s] = v;
        disp_src1[s*RW +: RW] = RW'(s1);
        disp_src2[s*RW +: RW] = RW'(s2);
        disp_dest[s*RW +: RW] = RW'(d);
        disp_tag[s*TW +: TW]  = TW'(t);
    endtask

    initial begin
        model_clear();
        idle();
        set_slot(0, 1, 5, 3, 5, 2);
        set_slot(1, 1, 5, 0, 6, 4);
        @(negedge clk);
        #1 check("rst_fwd", get_out(1, 1), {2'b00, NT});
        step("rst");
        rst_n = 1'b1;
        idle();
        set_slot(0, 0, 5, 9, 0, 0);
        step("empty");

        // rename, CDB, commit lifecycle on reg 5 / tag 3
        idle(); set_slot(0, 1, 0, 0, 5, 3); step("p1a");
        idle(); set_slot(0, 0, 5, 0, 0, 0);
        #1 check("p1_wait", get_out(0, 1), {2'b10, 4'd3});
        step("p1b");
        idle(); set_slot(0, 0, 5, 0, 0, 0); cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd3};
`ifdef MAP_TABLE_CDB_BYPASS_EN
        #1 check("p1_cdb_same", get_out(0, 1), {2'b11, 4'd3});
`else
        #1 check("p1_cdb_same", get_out(0, 1), {2'b10, 4'd3});
`endif
        step("p1c");
        idle(); set_slot(0, 0, 5, 0, 0, 0); commit_valid = 1'b1; commit_dest = 5'd5; commit_tag = 4'd3;
        #1 check("p1_ready", get_out(0, 1), {2'b11, 4'd3});
        step("p1d");
        idle(); set_slot(0, 0, 5, 0, 0, 0);
        #1 check("p1_committed", get_out(0, 1), {2'b00, NT});
        step("p1e");

        // intra-group forwarding and duplicate destinations
        idle(); set_slot(0, 1, 0, 0, 7, 2); set_slot(1, 0, 7, 0, 0, 0);
        #1 check("p2_fwd", get_out(1, 1), {2'b10, 4'd2});
        check("p2_zero", get_out(1, 2), {2'b00, NT});
        step("p2a");
        idle(); set_slot(0, 1, 0, 0, 9, 4); set_slot(1, 1, 0, 0, 9, 6); step("p2b");
        idle(); set_slot(0, 0, 9, 7, 0, 0);
        #1 check("p2_dup", get_out(0, 1), {2'b10, 4'd6});
        step("p2c");

        // stale commit, then commit+rename in the same cycle
        idle(); set_slot(0, 1, 0, 0, 8, 1); step("p3a");
        idle(); set_slot(0, 0, 8, 0, 0, 0); commit_valid = 1'b1; commit_dest = 5'd8; commit_tag = 4'd5; step("p3b");
        idle(); set_slot(0, 0, 8, 0, 0, 0);
        #1 check("p3_stale", get_out(0, 1), {2'b10, 4'd1});
        commit_valid = 1'b1; commit_dest = 5'd8; commit_tag = 4'd1; set_slot(0, 1, 8, 0, 8, 7);
        step("p3c");
        idle(); set_slot(0, 0, 8, 0, 0, 0);
        #1 check("p3_renamed", get_out(0, 1), {2'b10, 4'd7});
        step("p3d");

        // flush discards same-cycle CDB
        idle(); set_slot(0, 1, 0, 0, 3, 10); set_slot(1, 1, 0, 0, 4, 11); step("p4a");
        idle(); cdb_valid = 2'b10; cdb_tag = {4'd10, 4'd0}; flush = 1'b1; step("p4b");
        idle(); set_slot(0, 0, 3, 4, 0, 0); set_slot(1, 0, 4, 3, 0, 0);
        #1 check("p4_flush", get_out(0, 1), {2'b00, NT});
        check("p4_flush4", get_out(1, 1), {2'b00, NT});
        step("p4c");
        // asynchronous reset mid-run
        idle(); set_slot(0, 1, 0, 0, 5, 12); step("p4d");
        idle(); set_slot(0, 1, 5, 0, 5, 13); set_slot(1, 0, 5, 5, 0, 0);
        rst_n = 1'b0;
        #1 check("p4_rst_tbl", get_out(0, 1), {2'b00, NT});
        check("p4_rst_fwd", get_out(1, 1), {2'b00, NT});
        step("p4e");
        rst_n = 1'b1;
        idle(); set_slot(0, 0, 5, 0, 0, 0); step("p4f");

        // CDB bypass on a table entry
        idle(); set_slot(0, 1, 0, 0, 6, 2); step("p5a");
        idle(); set_slot(0, 0, 6, 0, 0, 0); cdb_valid = 2'b10; cdb_tag = {4'd2, 4'd0};
`ifdef MAP_TABLE_CDB_BYPASS_EN
        #1 check("p5_bypass", get_out(0, 1), {2'b11, 4'd2});
`else
        #1 check("p5_bypass", get_out(0, 1), {2'b10, 4'd2});
`endif
        step("p5b");
        idle(); set_slot(0, 0, 6, 0, 0, 0);
        #1 check("p5_next", get_out(0, 1), {2'b11, 4'd2});
        step("p5c");

        // randomized traffic on a small register window to force collisions
        for (int i = 0; i < 600; i++) begin
            idle();
            for (int s = 0; s < DW; s++)
                set_slot(s, bit'($urandom_range(0, 1)), $urandom_range(0, 9), $urandom_range(0, 9),
                         $urandom_range(0, 9), $urandom_range(0, 15));
            for (int c = 0; c < CW; c++) begin
                cdb_valid[c] = 1'($urandom_range(0, 1));
                cdb_tag[c*TW +: TW] = ($urandom_range(0, 1) != 0) ? m_tag[$urandom_range(0, 9)]
                                                                  : TW'($urandom_range(0, 15));
            end
            commit_valid = 1'($urandom_range(0, 1));
            commit_dest  = RW'($urandom_range(0, 9));
            commit_tag   = ($urandom_range(0, 2) != 0) ? m_tag[commit_dest] : TW'($urandom_range(0, 15));
            flush = ($urandom_range(0, 31) == 0);
            if (i == 300) rst_n = 1'b0;
            step("rnd");
            rst_n = 1'b1;
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
